// File: rtl/pixart_pkg.sv
// Shared constants, bus-state encoding and report layout for the Pixart camera emulator.
package pixart_pkg;
    localparam logic [6:0] ADDR_DEFAULT        = 7'h58;
    localparam logic [7:0] REPORT_BASE_DEFAULT = 8'h36;
    localparam int         REPORT_LEN          = 16;
    localparam logic [7:0] NO_BLOB             = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE, ST_ADDR, ST_ADDR_ACK, ST_WR_BYTE, ST_WR_ACK, ST_RD_BYTE, ST_RD_ACK
    } bus_state_t;

    // Extended-mode report byte k; only blob 1 is live, blobs 2-4 always read as absent.
    function automatic logic [7:0] report_byte(input logic [7:0] k, input logic [9:0] x,
                                               input logic [9:0] y, input logic [3:0] size,
                                               input logic valid);
        logic [7:0] b;
        b = 8'h00;
        if (k >= 8'd1 && k <= 8'd3) begin
            if (!valid)          b = NO_BLOB;
            else if (k == 8'd1)  b = x[7:0];
            else if (k == 8'd2)  b = y[7:0];
            else                 b = {y[9:8], x[9:8], size};
        end else if (k >= 8'd4 && k <= 8'd12) begin
            b = NO_BLOB;
        end
        return b;
    endfunction
endpackage

// File: rtl/i2c_line_sync.sv
// Bus line synchroniser with registered level and edge strobes: 3 clk latency, +2 clk when
// PIXART_GLITCH_FILTER_EN adds a 3-sample majority filter. No backpressure.
module i2c_line_sync (
    input  logic clk,
    input  logic reset,
    input  logic line,
    output logic level,
    output logic rise,
    output logic fall
);
    logic meta;
    logic synced;
    logic filt;

`ifdef PIXART_GLITCH_FILTER_EN
    logic [1:0] hist;
    logic       maj;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hist <= 2'b11;
            maj  <= 1'b1;
        end else begin
            hist <= {hist[0], synced};
            maj  <= (synced & hist[0]) | (synced & hist[1]) | (hist[0] & hist[1]);
        end
    end
    assign filt = maj;
`else
    assign filt = synced;
`endif

    // Idle bus is high, so resetting to 1 avoids a spurious edge out of reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta   <= 1'b1;
            synced <= 1'b1;
            level  <= 1'b1;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            meta   <= line;
            synced <= meta;
            level  <= filt;
            rise   <= filt & ~level;
            fall   <= ~filt & level;
        end
    end
endmodule

// File: rtl/pixart_emulator.sv
// I2C target standing in for the Pixart IR camera: config writes and 16-byte blob reports.
// SDA drive follows SCL falls by 4 clk (6 with PIXART_GLITCH_FILTER_EN); no backpressure, the initiator owns SCL.
module pixart_emulator
    import pixart_pkg::*;
#(
    parameter logic [6:0] ADDR        = ADDR_DEFAULT,
    parameter logic [7:0] REPORT_BASE = REPORT_BASE_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i2c_scl,
    input  logic       i2c_sda_in,
    output logic       i2c_sda_out,
    output logic       i2c_sda_dir,
    input  logic [9:0] blob_x,
    input  logic [9:0] blob_y,
    input  logic [3:0] blob_size,
    input  logic       blob_valid,
    output logic       cfg_strobe,
    output logic [7:0] cfg_addr,
    output logic [7:0] cfg_data
);
    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;
    logic start_det, stop_det;

    bus_state_t state, state_d;
    logic [2:0] bit_cnt, bit_cnt_d;
    logic [6:0] shreg, shreg_d;
    logic [7:0] byte_in;
    logic [7:0] ptr, ptr_d;
    logic       ptr_set, ptr_set_d;
    logic       rw, rw_d;
    logic       dir, dir_d;
    logic [7:0] tx, tx_d;
    logic       strobe_d;
    logic [7:0] cfg_addr_d, cfg_data_d;
    logic       snap;
    logic [7:0] report [REPORT_LEN];
    logic [7:0] rd_k, rd_byte;

    i2c_line_sync u_scl (.clk(clk), .reset(reset), .line(i2c_scl),
                         .level(scl_lvl), .rise(scl_rise), .fall(scl_fall));
    i2c_line_sync u_sda (.clk(clk), .reset(reset), .line(i2c_sda_in),
                         .level(sda_lvl), .rise(sda_rise), .fall(sda_fall));

    assign start_det   = sda_fall & scl_lvl;
    assign stop_det    = sda_rise & scl_lvl;
    assign i2c_sda_out = 1'b0;
    assign i2c_sda_dir = dir;

    always_comb begin
        rd_k    = ptr - REPORT_BASE;
        rd_byte = 8'h00;
        if (rd_k < 8'(REPORT_LEN)) rd_byte = report[rd_k[3:0]];
    end

    // In the ACK states, dir doubles as the phase flag: first SCL fall drives, second releases.
    always_comb begin
        state_d    = state;
        bit_cnt_d  = bit_cnt;
        shreg_d    = shreg;
        ptr_d      = ptr;
        ptr_set_d  = ptr_set;
        rw_d       = rw;
        dir_d      = dir;
        tx_d       = tx;
        strobe_d   = 1'b0;
        cfg_addr_d = cfg_addr;
        cfg_data_d = cfg_data;
        snap       = 1'b0;
        byte_in    = {shreg, sda_lvl};
        if (stop_det) begin
            state_d = ST_IDLE;
            dir_d   = 1'b0;
        end else if (start_det) begin
            state_d   = ST_ADDR;
            bit_cnt_d = 3'd0;
            dir_d     = 1'b0;
        end else begin
            case (state)
                ST_ADDR: if (scl_rise) begin
                    shreg_d   = byte_in[6:0];
                    bit_cnt_d = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        if (byte_in[7:1] == ADDR) begin
                            state_d = ST_ADDR_ACK;
                            rw_d    = byte_in[0];
                            if (!byte_in[0]) ptr_set_d = 1'b0;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                ST_ADDR_ACK: if (scl_fall) begin
                    if (!dir) begin
                        dir_d = 1'b1;
                        if (rw) begin
                            snap = 1'b1;
                            tx_d = report_byte(ptr - REPORT_BASE, blob_x, blob_y, blob_size, blob_valid);
                        end
                    end else begin
                        bit_cnt_d = 3'd0;
                        if (rw) begin
                            state_d = ST_RD_BYTE;
                            dir_d   = ~tx[7];
                            tx_d    = {tx[6:0], 1'b0};
                        end else begin
                            state_d = ST_WR_BYTE;
                            dir_d   = 1'b0;
                        end
                    end
                end
                ST_WR_BYTE: if (scl_rise) begin
                    shreg_d   = byte_in[6:0];
                    bit_cnt_d = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        state_d = ST_WR_ACK;
                        if (!ptr_set) begin
                            ptr_d     = byte_in;
                            ptr_set_d = 1'b1;
                        end else begin
                            strobe_d   = 1'b1;
                            cfg_addr_d = ptr;
                            cfg_data_d = byte_in;
                            ptr_d      = ptr + 8'd1;
                        end
                    end
                end
                ST_WR_ACK: if (scl_fall) begin
                    if (!dir) begin
                        dir_d = 1'b1;
                    end else begin
                        dir_d     = 1'b0;
                        state_d   = ST_WR_BYTE;
                        bit_cnt_d = 3'd0;
                    end
                end
                ST_RD_BYTE: begin
                    if (scl_fall) begin
                        dir_d = ~tx[7];
                        tx_d  = {tx[6:0], 1'b0};
                    end else if (scl_rise) begin
                        bit_cnt_d = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state_d = ST_RD_ACK;
                            ptr_d   = ptr + 8'd1;
                        end
                    end
                end
                ST_RD_ACK: begin
                    if (scl_fall) begin
                        dir_d = 1'b0;
                    end else if (scl_rise) begin
                        if (!sda_lvl) begin
                            state_d   = ST_RD_BYTE;
                            bit_cnt_d = 3'd0;
                            tx_d      = rd_byte;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            bit_cnt    <= 3'd0;
            shreg      <= 7'd0;
            ptr        <= 8'd0;
            ptr_set    <= 1'b0;
            rw         <= 1'b0;
            dir        <= 1'b0;
            tx         <= 8'd0;
            cfg_strobe <= 1'b0;
            cfg_addr   <= 8'd0;
            cfg_data   <= 8'd0;
            for (int i = 0; i < REPORT_LEN; i++) report[i] <= NO_BLOB;
        end else begin
            state      <= state_d;
            bit_cnt    <= bit_cnt_d;
            shreg      <= shreg_d;
            ptr        <= ptr_d;
            ptr_set    <= ptr_set_d;
            rw         <= rw_d;
            dir        <= dir_d;
            tx         <= tx_d;
            cfg_strobe <= strobe_d;
            cfg_addr   <= cfg_addr_d;
            cfg_data   <= cfg_data_d;
            if (snap) begin
                for (int i = 0; i < REPORT_LEN; i++)
                    report[i] <= report_byte(8'(i), blob_x, blob_y, blob_size, blob_valid);
            end
        end
    end
endmodule

// File: tb/tb_pixart_emulator.sv
// Directed bench for pixart_emulator: bit-banged I2C initiator with hand-computed expectations.
`timescale 1ns/1ps
module tb_pixart_emulator;
    import pixart_pkg::*;

    localparam int Q = 6;

    logic       clk = 1'b0;
    logic       reset;
    logic       scl;
    logic       sda_drv;
    logic [9:0] blob_x, blob_y;
    logic [3:0] blob_size;
    logic       blob_valid;
    logic       sda_out, sda_dir, cfg_strobe;
    logic [7:0] cfg_addr, cfg_data;
    wire        sda_line = sda_drv & ~sda_dir;

    int         vectors = 0;
    int         miscompares = 0;
    int         strobe_cnt = 0;
    int         strobe_base;
    logic [7:0] last_addr, last_data;
    logic       dir_seen;
    logic       ack;
    logic [7:0] rdat;
    logic [7:0] exp_rep [16];

    always #5 clk = ~clk;

    pixart_emulator dut (
        .clk(clk), .reset(reset), .i2c_scl(scl), .i2c_sda_in(sda_line),
        .i2c_sda_out(sda_out), .i2c_sda_dir(sda_dir),
        .blob_x(blob_x), .blob_y(blob_y), .blob_size(blob_size), .blob_valid(blob_valid),
        .cfg_strobe(cfg_strobe), .cfg_addr(cfg_addr), .cfg_data(cfg_data)
    );

    always @(negedge clk) begin
        if (cfg_strobe) begin
            strobe_cnt = strobe_cnt + 1;
            last_addr  = cfg_addr;
            last_data  = cfg_data;
        end
        if (sda_dir) dir_seen = 1'b1;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start();
        sda_drv = 1'b1; wait_clk(Q);
        scl = 1'b1;     wait_clk(Q);
        sda_drv = 1'b0; wait_clk(Q);
        scl = 1'b0;     wait_clk(Q);
    endtask

    task automatic i2c_stop();
        sda_drv = 1'b0; wait_clk(Q);
        scl = 1'b1;     wait_clk(Q);
        sda_drv = 1'b1; wait_clk(Q);
    endtask

    task automatic send_bit(input logic b);
        sda_drv = b; wait_clk(Q);
        scl = 1'b1;  wait_clk(2 * Q);
        scl = 1'b0;  wait_clk(Q);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack_bit);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        sda_drv = 1'b1; wait_clk(Q);
        scl = 1'b1;     wait_clk(Q);
        ack_bit = sda_line;
        wait_clk(Q);
        scl = 1'b0;     wait_clk(Q);
    endtask

    task automatic read_byte(input logic give_ack, output logic [7:0] d);
        sda_drv = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            wait_clk(Q);
            scl = 1'b1; wait_clk(Q);
            d[i] = sda_line;
            wait_clk(Q);
            scl = 1'b0; wait_clk(Q);
        end
        send_bit(~give_ack);
    endtask

    // Set the pointer to the report base, then repeated START into a read.
    task automatic read_setup(input string tag);
        i2c_start();
        write_byte(8'hB0, ack); check({tag, "_ack_b0"}, 32'(ack), 32'd0);
        write_byte(8'h36, ack); check({tag, "_ack_ptr"}, 32'(ack), 32'd0);
        i2c_start();
        write_byte(8'hB1, ack); check({tag, "_ack_b1"}, 32'(ack), 32'd0);
    endtask

    task automatic read_block(input string tag, input int n, input logic move_blob);
        for (int i = 0; i < n; i++) begin
            read_byte(i != n - 1, rdat);
            check($sformatf("%s_byte%0d", tag, i), 32'(rdat), 32'(exp_rep[i]));
            if (move_blob && i == 0) blob_x = 10'd400;
        end
        i2c_stop();
    endtask

    initial begin
        reset = 1'b1; scl = 1'b1; sda_drv = 1'b1; dir_seen = 1'b0;
        blob_x = 10'd300; blob_y = 10'd200; blob_size = 4'd5; blob_valid = 1'b1;
        wait_clk(4);
        check("rst_dir", 32'(sda_dir), 32'd0);
        check("rst_out", 32'(sda_out), 32'd0);
        check("rst_strobe", 32'(cfg_strobe), 32'd0);
        check("rst_addr", 32'(cfg_addr), 32'd0);
        check("rst_data", 32'(cfg_data), 32'd0);
        reset = 1'b0;
        wait_clk(10);

        // Config write: pointer 0x30, data 0x01.
        strobe_base = strobe_cnt;
        i2c_start();
        write_byte(8'hB0, ack); check("wr_ack_addr", 32'(ack), 32'd0);
        write_byte(8'h30, ack); check("wr_ack_ptr", 32'(ack), 32'd0);
        write_byte(8'h01, ack); check("wr_ack_data", 32'(ack), 32'd0);
        i2c_stop();
        wait_clk(4);
        check("wr_strobes", 32'(strobe_cnt - strobe_base), 32'd1);
        check("wr_cfg_addr", 32'(last_addr), 32'h30);
        check("wr_cfg_data", 32'(last_data), 32'h01);

        // Full report read with blob present.
        exp_rep = '{8'h00, 8'h2C, 8'hC8, 8'h15, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
                    8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00};
        strobe_base = strobe_cnt;
        read_setup("rdv");
        read_block("rdv", 16, 1'b0);
        check("rdv_no_strobe", 32'(strobe_cnt - strobe_base), 32'd0);

        // Blob absent.
        blob_valid = 1'b0;
        exp_rep = '{8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
                    8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00};
        read_setup("rdn");
        read_block("rdn", 16, 1'b0);
        blob_valid = 1'b1;

        // Foreign address 0x21: never ACKed, SDA never pulled.
        wait_clk(4);
        dir_seen = 1'b0;
        i2c_start();
        write_byte(8'h42, ack); check("bad_ack_addr", 32'(ack), 32'd1);
        write_byte(8'h55, ack); check("bad_ack_d0", 32'(ack), 32'd1);
        write_byte(8'hAA, ack); check("bad_ack_d1", 32'(ack), 32'd1);
        i2c_stop();
        check("bad_dir_seen", 32'(dir_seen), 32'd0);

        // Blob moves after the snapshot: this read keeps x=300, the next sees x=400.
        exp_rep = '{8'h00, 8'h2C, 8'hC8, 8'h15, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
                    8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00};
        read_setup("snap");
        read_block("snap", 16, 1'b1);
        exp_rep[1] = 8'h90;
        read_setup("post");
        read_block("post", 4, 1'b0);
        blob_x = 10'd300;

        // STOP after a partial data byte.
        strobe_base = strobe_cnt;
        i2c_start();
        write_byte(8'hB0, ack); check("part_ack_addr", 32'(ack), 32'd0);
        write_byte(8'h10, ack); check("part_ack_ptr", 32'(ack), 32'd0);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        i2c_stop();
        check("part_dir", 32'(sda_dir), 32'd0);
        check("part_state", 32'(dut.state), 32'(ST_IDLE));
        check("part_no_strobe", 32'(strobe_cnt - strobe_base), 32'd0);

        // Reset pulse while the address ACK is being driven.
        i2c_start();
        for (int i = 7; i >= 0; i--) send_bit(i == 7 || i == 5 || i == 4);
        sda_drv = 1'b1;
        check("rst_mid_dir_before", 32'(sda_dir), 32'd1);
        reset = 1'b1;
        #1;
        check("rst_mid_dir_async", 32'(sda_dir), 32'd0);
        wait_clk(2);
        reset = 1'b0;
        wait_clk(Q);
        scl = 1'b1; wait_clk(2 * Q);
        scl = 1'b0; wait_clk(Q);
        dir_seen = 1'b0;
        write_byte(8'h30, ack); check("rst_mid_ack0", 32'(ack), 32'd1);
        write_byte(8'h77, ack); check("rst_mid_ack1", 32'(ack), 32'd1);
        i2c_stop();
        check("rst_mid_dir_seen", 32'(dir_seen), 32'd0);
        check("rst_mid_state", 32'(dut.state), 32'(ST_IDLE));
        check("rst_mid_no_strobe", 32'(strobe_cnt - strobe_base), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
